// File: rtl/cp_pkg.sv
// Shared types for the coprocessor dispatcher.
//   cp_id_t       : coprocessor channel index
//   OPC_*         : major opcodes that route to a coprocessor channel
//   tag_entry_t   : per-op bookkeeping kept in program order (channel, destination reg)
//   decode_opcode : maps inst[6:0] to {hit, channel}
package cp_pkg;

    typedef logic [1:0] cp_id_t;

    localparam logic [6:0] OPC_SYSTEM  = 7'h73;
    localparam logic [6:0] OPC_FP      = 7'h53;
    localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
    localparam logic [6:0] OPC_CUSTOM1 = 7'h2B;

    typedef struct packed {
        cp_id_t     cp;
        logic [4:0] rd;
    } tag_entry_t;

    typedef struct packed {
        logic   hit;
        cp_id_t id;
    } cp_decode_t;

    function automatic cp_decode_t decode_opcode(input logic [6:0] opc);
        cp_decode_t d;
        d = '0;
        case (opc)
            OPC_SYSTEM:  d = '{hit: 1'b1, id: 2'd0};
            OPC_FP:      d = '{hit: 1'b1, id: 2'd1};
            OPC_CUSTOM0: d = '{hit: 1'b1, id: 2'd2};
            OPC_CUSTOM1: d = '{hit: 1'b1, id: 2'd3};
            default:     d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp_tag_fifo.sv
// In-order tag FIFO for in-flight coprocessor ops.
// Show-ahead: head is valid whenever empty is low. Push and pop may happen in
// the same cycle (occupancy unchanged). Callers never push when full or pop
// when empty.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data at the tail
//   push_data  : entry to store
//   pop        : drop the head entry
//   head       : oldest entry
//   full/empty : registered occupancy flags
//   count      : registered occupancy
module cp_tag_fifo
    import cp_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  tag_entry_t                     push_data,
    input  logic                           pop,
    output tag_entry_t                     head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    tag_entry_t       mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/cp_dispatch_queue.sv
// Coprocessor dispatcher between the ID/EX register and the coprocessor system.
// Decodes the instruction, issues it to one coprocessor channel over a
// valid/ready handshake, keeps in-flight ops in program order and retires the
// oldest one through a registered writeback port, with a per-op timeout.
//   clk, rst_n                     : clock, async active-low reset
//   inst, inst_valid               : ID/EX instruction
//   rs1_data, rs2_data             : operands (rs2 carried, not yet used)
//   pipeline_stall                 : pipeline held, no issue
//   cp_detected, stall_request     : decode hit / issue blocked
//   req_valid/ready, req_inst/data : issue handshake (valid one-hot)
//   rsp_valid/ready/data/exception : response handshake (ready one-hot, head channel)
//   wb_*                           : registered writeback, one-cycle pulse
//   outstanding                    : queue occupancy
module cp_dispatch_queue
    import cp_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int INST_WIDTH      = 32,
    parameter int CP_NUM          = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
)(
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [INST_WIDTH-1:0]                 inst,
    input  logic                                  inst_valid,
    input  logic [DATA_WIDTH-1:0]                 rs1_data,
    input  logic [DATA_WIDTH-1:0]                 rs2_data,
    input  logic                                  pipeline_stall,
    output logic                                  cp_detected,
    output logic                                  stall_request,
    output logic [CP_NUM-1:0]                     req_valid,
    input  logic [CP_NUM-1:0]                     req_ready,
    output logic [INST_WIDTH-1:0]                 req_inst,
    output logic [DATA_WIDTH-1:0]                 req_data,
    input  logic [CP_NUM-1:0]                     rsp_valid,
    output logic [CP_NUM-1:0]                     rsp_ready,
    input  logic [CP_NUM*DATA_WIDTH-1:0]          rsp_data,
    input  logic [CP_NUM-1:0]                     rsp_exception,
    output logic                                  wb_valid,
    output logic [4:0]                            wb_rd,
    output logic [DATA_WIDTH-1:0]                 wb_data,
    output logic                                  wb_exception,
    output logic                                  wb_timeout,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    cp_decode_t            dec;
    cp_id_t                sel;
    logic                  ready_sel;
    logic                  fire;
    tag_entry_t            head;
    logic                  full;
    logic                  empty;
    logic                  head_rsp_valid;
    logic                  head_rsp_exc;
    logic [DATA_WIDTH-1:0] head_rsp_data;
    logic                  accept;
    logic                  tmo_hit;
    logic                  pop;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  wb_exc_q, wb_exc_d;
    logic                  wb_to_q, wb_to_d;
    logic                  rs2_unused;

    assign rs2_unused = ^rs2_data;

    assign dec         = decode_opcode(inst[6:0]);
    assign sel         = dec.id;
    assign cp_detected = inst_valid & dec.hit & (int'(dec.id) < CP_NUM);

    // Per-channel muxing by loop keeps every index inside [0, CP_NUM).
    always_comb begin
        ready_sel      = 1'b0;
        head_rsp_valid = 1'b0;
        head_rsp_exc   = 1'b0;
        head_rsp_data  = '0;
        for (int i = 0; i < CP_NUM; i++) begin
            if (sel == cp_id_t'(i)) begin
                ready_sel = req_ready[i];
            end
            if (head.cp == cp_id_t'(i)) begin
                head_rsp_valid = rsp_valid[i];
                head_rsp_exc   = rsp_exception[i];
                head_rsp_data  = rsp_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Nothing issues while reset is asserted, so req_valid reads 0 then.
    assign fire          = rst_n & cp_detected & ~pipeline_stall & ~full & ready_sel;
    assign stall_request = cp_detected & (full | ~ready_sel);

    always_comb begin
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < CP_NUM; i++) begin
            req_valid[i] = fire & (sel == cp_id_t'(i));
            rsp_ready[i] = ~empty & (head.cp == cp_id_t'(i));
        end
    end

    assign req_inst = inst;
    assign req_data = rs1_data;

    // A response arriving on the timeout-limit cycle takes priority.
    assign accept  = ~empty & head_rsp_valid;
    assign tmo_hit = ~empty & ~accept & (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign pop     = accept | tmo_hit;

    cp_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_data ('{cp: sel, rd: inst[11:7]}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (outstanding)
    );

    always_comb begin
        tmo_cnt_d  = (pop | empty) ? '0 : tmo_cnt_q + TW'(1);
        wb_valid_d = pop;
        wb_rd_d    = pop ? head.rd : 5'd0;
        wb_data_d  = accept ? head_rsp_data : '0;
        wb_exc_d   = accept ? head_rsp_exc : tmo_hit;
        wb_to_d    = tmo_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_exc_q   <= 1'b0;
            wb_to_q    <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_exc_q   <= wb_exc_d;
            wb_to_q    <= wb_to_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exc_q;
    assign wb_timeout   = wb_to_q;

endmodule

// File: tb/tb_cp_dispatch_queue.sv
// Bench for cp_dispatch_queue: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the dispatcher.
module tb_cp_dispatch_queue;

    localparam int DW   = 64;
    localparam int IW   = 32;
    localparam int CPN  = 3;
    localparam int MAXO = 4;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [IW-1:0]   inst;
    logic            inst_valid;
    logic [DW-1:0]   rs1_data, rs2_data;
    logic            pipeline_stall;
    logic            cp_detected, stall_request;
    logic [CPN-1:0]  req_valid, req_ready;
    logic [IW-1:0]   req_inst;
    logic [DW-1:0]   req_data;
    logic [CPN-1:0]  rsp_valid, rsp_ready, rsp_exception;
    logic [CPN*DW-1:0] rsp_data;
    logic            wb_valid, wb_exception, wb_timeout;
    logic [4:0]      wb_rd;
    logic [DW-1:0]   wb_data;
    logic [2:0]      outstanding;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] opc_tab [4];

    // reference model state
    int          mq_cp[$];
    int          mq_rd[$];
    int          age;
    logic        e_wbv, e_exc, e_to;
    logic [4:0]  e_rd;
    logic [DW-1:0] e_data;

    cp_dispatch_queue #(
        .DATA_WIDTH(DW), .INST_WIDTH(IW), .CP_NUM(CPN),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pipeline_stall(pipeline_stall),
        .cp_detected(cp_detected), .stall_request(stall_request),
        .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_exception(rsp_exception), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_exception(wb_exception), .wb_timeout(wb_timeout),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int chan_of(input logic [IW-1:0] x);
        int c;
        case (x[6:0])
            7'h73:   c = 0;
            7'h53:   c = 1;
            7'h0B:   c = 2;
            7'h2B:   c = 3;
            default: c = -1;
        endcase
        if (c >= CPN) c = -1;
        return c;
    endfunction

    function automatic logic exp_det();
        return inst_valid && (chan_of(inst) >= 0);
    endfunction

    function automatic logic exp_fire();
        int c;
        c = chan_of(inst);
        if (!rst_n || !inst_valid || c < 0 || pipeline_stall) return 1'b0;
        if (mq_cp.size() >= MAXO) return 1'b0;
        return req_ready[c];
    endfunction

    function automatic logic exp_stall();
        int c;
        c = chan_of(inst);
        if (!inst_valid || c < 0) return 1'b0;
        return (mq_cp.size() == MAXO) || !req_ready[c];
    endfunction

    function automatic logic [CPN-1:0] exp_req_valid();
        logic [CPN-1:0] r;
        r = '0;
        if (exp_fire()) r[chan_of(inst)] = 1'b1;
        return r;
    endfunction

    function automatic logic [CPN-1:0] exp_rsp_ready();
        logic [CPN-1:0] r;
        r = '0;
        if (mq_cp.size() > 0) r[mq_cp[0]] = 1'b1;
        return r;
    endfunction

    function automatic logic [IW-1:0] mk_inst(input int ch, input logic [4:0] rd);
        logic [IW-1:0] r;
        r      = $urandom;
        r[11:7] = rd;
        r[6:0]  = opc_tab[ch];
        return r;
    endfunction

    task automatic idle();
        inst_valid     = 1'b0;
        inst           = '0;
        rs1_data       = '0;
        rs2_data       = '0;
        pipeline_stall = 1'b0;
        req_ready      = '0;
        rsp_valid      = '0;
        rsp_exception  = '0;
        rsp_data       = '0;
    endtask

    task automatic model_reset();
        mq_cp.delete();
        mq_rd.delete();
        age    = 0;
        e_wbv  = 1'b0;
        e_rd   = '0;
        e_data = '0;
        e_exc  = 1'b0;
        e_to   = 1'b0;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        logic f, acc, tmo;
        int   c, hc;
        f   = exp_fire();
        c   = chan_of(inst);
        acc = 1'b0;
        tmo = 1'b0;
        hc  = 0;
        if (mq_cp.size() > 0) begin
            hc  = mq_cp[0];
            acc = rsp_valid[hc];
            tmo = !acc && (age == TMO - 1);
        end
        e_wbv  = acc || tmo;
        e_rd   = (acc || tmo) ? 5'(mq_rd[0]) : 5'd0;
        e_data = acc ? rsp_data[hc*DW +: DW] : '0;
        e_exc  = acc ? rsp_exception[hc] : tmo;
        e_to   = tmo;
        age    = (acc || tmo || mq_cp.size() == 0) ? 0 : age + 1;
        if (acc || tmo) begin
            void'(mq_cp.pop_front());
            void'(mq_rd.pop_front());
        end
        if (f) begin
            mq_cp.push_back(c);
            mq_rd.push_back(int'(inst[11:7]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (req_valid !== '0)   begin n_fail++; $display("FAIL rst_req_valid got=%b exp=0", req_valid); end
        n_chk++; if (rsp_ready !== '0)   begin n_fail++; $display("FAIL rst_rsp_ready got=%b exp=0", rsp_ready); end
        n_chk++; if (wb_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
        n_chk++; if (outstanding !== '0) begin n_fail++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        n_chk++; if (wb_data !== '0)     begin n_fail++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
    endtask

    task automatic test_basic_issue();
        inst = mk_inst(1, 5'd5); inst_valid = 1'b1; rs1_data = 64'hA5; req_ready = 3'b010;
        #1;
        n_chk++; if (req_valid !== 3'b010)  begin n_fail++; $display("FAIL t1_req_valid got=%b exp=010", req_valid); end
        n_chk++; if (req_data !== 64'hA5)   begin n_fail++; $display("FAIL t1_req_data got=%h exp=a5", req_data); end
        n_chk++; if (stall_request !== 1'b0) begin n_fail++; $display("FAIL t1_stall got=%b exp=0", stall_request); end
        tick();
        inst_valid = 1'b0;
        n_chk++; if (outstanding !== 3'd1)  begin n_fail++; $display("FAIL t1_outstanding got=%0d exp=1", outstanding); end
        tick();
        rsp_valid = 3'b010; rsp_data[1*DW +: DW] = 64'h1234;
        #1;
        n_chk++; if (rsp_ready !== 3'b010)  begin n_fail++; $display("FAIL t1_rsp_ready got=%b exp=010", rsp_ready); end
        tick();
        rsp_valid = '0;
        n_chk++; if (wb_valid !== 1'b1)     begin n_fail++; $display("FAIL t1_wb_valid got=%b exp=1", wb_valid); end
        n_chk++; if (wb_rd !== 5'd5)        begin n_fail++; $display("FAIL t1_wb_rd got=%0d exp=5", wb_rd); end
        n_chk++; if (wb_data !== 64'h1234)  begin n_fail++; $display("FAIL t1_wb_data got=%h exp=1234", wb_data); end
        n_chk++; if (wb_timeout !== 1'b0)   begin n_fail++; $display("FAIL t1_wb_timeout got=%b exp=0", wb_timeout); end
        tick();
        n_chk++; if (wb_valid !== 1'b0)     begin n_fail++; $display("FAIL t1_wb_pulse got=%b exp=0", wb_valid); end
        n_chk++; if (outstanding !== 3'd0)  begin n_fail++; $display("FAIL t1_drained got=%0d exp=0", outstanding); end
    endtask

    task automatic test_fill();
        int chs [4] = '{0, 2, 0, 1};
        logic [CPN-1:0] ev;
        req_ready = 3'b111;
        for (int j = 0; j < 4; j++) begin
            inst = mk_inst(chs[j], 5'(j + 1)); inst_valid = 1'b1;
            #1;
            ev = '0; ev[chs[j]] = 1'b1;
            n_chk++; if (req_valid !== ev) begin n_fail++; $display("FAIL t2_issue%0d got=%b exp=%b", j, req_valid, ev); end
            tick();
        end
        inst = mk_inst(2, 5'd9);
        #1;
        n_chk++; if (outstanding !== 3'd4)    begin n_fail++; $display("FAIL t2_outstanding got=%0d exp=4", outstanding); end
        n_chk++; if (stall_request !== 1'b1)  begin n_fail++; $display("FAIL t2_full_stall got=%b exp=1", stall_request); end
        n_chk++; if (req_valid !== '0)        begin n_fail++; $display("FAIL t2_full_noissue got=%b exp=0", req_valid); end
        pipeline_stall = 1'b1;
        #1;
        n_chk++; if (stall_request !== 1'b1)  begin n_fail++; $display("FAIL t2_stall_pstall got=%b exp=1", stall_request); end
        pipeline_stall = 1'b0;
        inst_valid = 1'b0;
    endtask

    task automatic test_head_order();
        rsp_valid = 3'b100; rsp_data[2*DW +: DW] = 64'h22; rsp_data[0 +: DW] = 64'h11;
        #1;
        n_chk++; if (rsp_ready !== 3'b001)  begin n_fail++; $display("FAIL t3_rsp_ready0 got=%b exp=001", rsp_ready); end
        tick();
        n_chk++; if (wb_valid !== 1'b0)     begin n_fail++; $display("FAIL t3_ch2_ignored got=%b exp=0", wb_valid); end
        n_chk++; if (outstanding !== 3'd4)  begin n_fail++; $display("FAIL t3_no_pop got=%0d exp=4", outstanding); end
        rsp_valid = 3'b101;
        tick();
        rsp_valid = 3'b100;
        n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 64'h11)
            begin n_fail++; $display("FAIL t3_ch0_retire got=%b/%0d/%h exp=1/1/11", wb_valid, wb_rd, wb_data); end
        n_chk++; if (rsp_ready !== 3'b100)  begin n_fail++; $display("FAIL t3_rsp_ready2 got=%b exp=100", rsp_ready); end
        tick();
        rsp_valid = '0;
        n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 64'h22)
            begin n_fail++; $display("FAIL t3_ch2_retire got=%b/%0d/%h exp=1/2/22", wb_valid, wb_rd, wb_data); end
        repeat (20) tick();
        n_chk++; if (outstanding !== 3'd0)  begin n_fail++; $display("FAIL t3_drain got=%0d exp=0", outstanding); end
    endtask

    task automatic test_timeout();
        req_ready = 3'b001;
        inst = mk_inst(0, 5'd7); inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL t4_early_wb k=%0d got=%b exp=0", k, wb_valid); end
            end
        end
        n_chk++; if ({wb_valid, wb_exception, wb_timeout} !== 3'b111)
            begin n_fail++; $display("FAIL t4_timeout_flags got=%b exp=111", {wb_valid, wb_exception, wb_timeout}); end
        n_chk++; if (wb_data !== '0)        begin n_fail++; $display("FAIL t4_timeout_data got=%h exp=0", wb_data); end
        n_chk++; if (outstanding !== 3'd0)  begin n_fail++; $display("FAIL t4_outstanding got=%0d exp=0", outstanding); end
        tick();
        n_chk++; if (wb_valid !== 1'b0)     begin n_fail++; $display("FAIL t4_pulse got=%b exp=0", wb_valid); end
        // response on the timeout-limit cycle retires normally
        req_ready = 3'b100;
        inst = mk_inst(2, 5'd11); inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        repeat (7) tick();
        n_chk++; if (wb_valid !== 1'b0)     begin n_fail++; $display("FAIL t4_limit_prewb got=%b exp=0", wb_valid); end
        rsp_valid = 3'b100; rsp_data[2*DW +: DW] = 64'hBEEF;
        tick();
        rsp_valid = '0;
        n_chk++; if ({wb_valid, wb_exception, wb_timeout} !== 3'b100 || wb_data !== 64'hBEEF || wb_rd !== 5'd11)
            begin n_fail++; $display("FAIL t4_limit_rsp_wins got=%b/%h/%0d exp=100/beef/11", {wb_valid, wb_exception, wb_timeout}, wb_data, wb_rd); end
    endtask

    task automatic test_exception();
        req_ready = 3'b010;
        inst = mk_inst(1, 5'd9); inst_valid = 1'b1;
        tick();
        inst_valid = 1'b0;
        rsp_valid = 3'b010; rsp_exception = 3'b010; rsp_data[1*DW +: DW] = 64'hCAFE;
        tick();
        rsp_valid = '0; rsp_exception = '0;
        n_chk++; if ({wb_valid, wb_exception, wb_timeout} !== 3'b110)
            begin n_fail++; $display("FAIL t5_flags got=%b exp=110", {wb_valid, wb_exception, wb_timeout}); end
        n_chk++; if (wb_data !== 64'hCAFE || wb_rd !== 5'd9)
            begin n_fail++; $display("FAIL t5_data got=%h/%0d exp=cafe/9", wb_data, wb_rd); end
    endtask

    task automatic test_async_reset();
        int chs [4] = '{0, 1, 2, 0};
        req_ready = 3'b111;
        for (int j = 0; j < 4; j++) begin
            inst = mk_inst(chs[j], 5'(j + 3)); inst_valid = 1'b1;
            tick();
        end
        inst_valid = 1'b0;
        rsp_valid = 3'b001; rsp_data[0 +: DW] = 64'h77;
        tick();
        n_chk++; if (wb_valid !== 1'b1 || outstanding !== 3'd3)
            begin n_fail++; $display("FAIL t6_setup got=%b/%0d exp=1/3", wb_valid, outstanding); end
        inst = mk_inst(1, 5'd4); inst_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++; if (req_valid !== '0 || rsp_ready !== '0 || outstanding !== '0)
            begin n_fail++; $display("FAIL t6_rst_hs got=%b/%b/%0d exp=0/0/0", req_valid, rsp_ready, outstanding); end
        n_chk++; if ({wb_valid, wb_exception, wb_timeout} !== 3'b000 || wb_data !== '0 || wb_rd !== '0)
            begin n_fail++; $display("FAIL t6_rst_wb got=%b/%h/%0d exp=000/0/0", {wb_valid, wb_exception, wb_timeout}, wb_data, wb_rd); end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle();
        req_ready = 3'b010;
        inst = mk_inst(1, 5'd3); inst_valid = 1'b1;
        #1;
        n_chk++; if (req_valid !== 3'b010 || outstanding !== 3'd0)
            begin n_fail++; $display("FAIL t6_post_issue got=%b/%0d exp=010/0", req_valid, outstanding); end
        tick();
        inst_valid = 1'b0;
        n_chk++; if (outstanding !== 3'd1)  begin n_fail++; $display("FAIL t6_post_occ got=%0d exp=1", outstanding); end
        rsp_valid = 3'b010;
        tick();
        rsp_valid = '0;
        n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3)
            begin n_fail++; $display("FAIL t6_post_retire got=%b/%0d exp=1/3", wb_valid, wb_rd); end
    endtask

    task automatic test_random();
        int k, p;
        logic [6:0] opc;
        for (int n = 0; n < 500; n++) begin
            p   = (n < 250) ? 30 : 6;
            k   = $urandom_range(0, 4);
            opc = (k < 4) ? opc_tab[k] : 7'h33;
            inst       = $urandom;
            inst[6:0]  = opc;
            inst_valid = ($urandom_range(0, 9) < 7);
            pipeline_stall = ($urandom_range(0, 9) < 2);
            req_ready  = CPN'($urandom);
            for (int b = 0; b < CPN; b++) rsp_valid[b] = ($urandom_range(0, 99) < p);
            rsp_exception = CPN'($urandom);
            for (int b = 0; b < CPN * 2; b++) rsp_data[b*32 +: 32] = $urandom;
            rs1_data = {$urandom, $urandom};
            #1;
            n_chk++; if (cp_detected !== exp_det())       begin n_fail++; $display("FAIL rnd_det n=%0d got=%b exp=%b", n, cp_detected, exp_det()); end
            n_chk++; if (stall_request !== exp_stall())   begin n_fail++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_request, exp_stall()); end
            n_chk++; if (req_valid !== exp_req_valid())   begin n_fail++; $display("FAIL rnd_req_valid n=%0d got=%b exp=%b", n, req_valid, exp_req_valid()); end
            n_chk++; if (rsp_ready !== exp_rsp_ready())   begin n_fail++; $display("FAIL rnd_rsp_ready n=%0d got=%b exp=%b", n, rsp_ready, exp_rsp_ready()); end
            n_chk++; if (int'(outstanding) != mq_cp.size()) begin n_fail++; $display("FAIL rnd_outstanding n=%0d got=%0d exp=%0d", n, outstanding, mq_cp.size()); end
            n_chk++; if (req_data !== rs1_data || req_inst !== inst) begin n_fail++; $display("FAIL rnd_req_payload n=%0d got=%h exp=%h", n, req_data, rs1_data); end
            tick();
            n_chk++; if (wb_valid !== e_wbv) begin n_fail++; $display("FAIL rnd_wb_valid n=%0d got=%b exp=%b", n, wb_valid, e_wbv); end
            if (e_wbv) begin
                n_chk++; if (wb_data !== e_data || wb_exception !== e_exc || wb_timeout !== e_to)
                    begin n_fail++; $display("FAIL rnd_wb_fields n=%0d got=%h/%b/%b exp=%h/%b/%b", n, wb_data, wb_exception, wb_timeout, e_data, e_exc, e_to); end
                if (!e_to) begin
                    n_chk++; if (wb_rd !== e_rd) begin n_fail++; $display("FAIL rnd_wb_rd n=%0d got=%0d exp=%0d", n, wb_rd, e_rd); end
                end
            end
        end
        idle();
    endtask

    initial begin
        opc_tab = '{7'h73, 7'h53, 7'h0B, 7'h2B};
        rst_n = 1'b0;
        idle();
        model_reset();
        test_reset();
        #11;
        rst_n = 1'b1;
        test_basic_issue();
        idle();
        test_fill();
        test_head_order();
        idle();
        test_timeout();
        idle();
        test_exception();
        idle();
        test_async_reset();
        idle();
        test_random();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
